// File: rtl/serial_bus_pkg.sv
// Shared definitions for the bit-serial bus: response status codes, request mode
// bits, slave FSM states and default widths.
package serial_bus_pkg;

   localparam int DEF_ADDR_W    = 12;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MEM_DEPTH = 2048;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_OK     = 2'b00,
      ST_SPLIT  = 2'b01,
      ST_RESUME = 2'b10,
      ST_ERR    = 2'b11
   } status_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RX_MODE,
      S_RX_ADDR,
      S_RX_DATA,
      S_EXEC,
      S_SPLIT_WAIT,
      S_TX_START,
      S_TX_STAT,
      S_TX_DATA,
      S_TX_STOP
   } slave_state_e;

   // Only successful or resumed reads carry a data field in the response.
   function automatic logic frame_has_data(input logic mode, input status_e st);
      return (mode == MODE_READ) && ((st == ST_OK) || (st == ST_RESUME));
   endfunction

endpackage

// File: rtl/serial_slave_port_if.sv
// Serial link between a decoder slave slot and a slave port, plus the slave's
// local busy/status signals.
interface serial_slave_port_if;
   logic rx;
   logic tx;
   logic busy;
   logic ready;
   logic split_pending;

   modport slave  (input rx, busy, output tx, ready, split_pending);
   modport master (output rx, busy, input tx, ready, split_pending);
endinterface

// File: rtl/serial_slave_mem.sv
// Local register memory of the slave port: synchronous write, combinational
// read, contents are not reset.
module serial_slave_mem #(
   parameter int DEPTH  = 2048,
   parameter int DATA_W = 8,
   parameter int AW     = 11
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/serial_slave_port.sv
// Serial bus slave: deserialises a request, executes it against local memory
// and serialises the response, deferring via SPLIT/RESUME while busy.
module serial_slave_port
   import serial_bus_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
   input logic                clk,
   input logic                rst,
   serial_slave_port_if.slave bus
);

   localparam int MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   slave_state_e      r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic              r_mode;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   status_e           r_status, w_status_next;
   logic [DATA_W-1:0] r_rdata, w_rdata_next;
   logic              r_tx, w_tx_next;
   logic              r_split_pending, w_split_next;
   logic              w_we;
   logic              w_addr_ok;
   logic [1:0]        w_stat_bits;
   logic [DATA_W-1:0] w_mem_rdata;

   serial_slave_mem #(.DEPTH(MEM_DEPTH), .DATA_W(DATA_W), .AW(MEM_AW)) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (r_addr[MEM_AW-1:0]),
      .i_wdata (r_data),
      .o_rdata (w_mem_rdata)
   );

   assign w_addr_ok = 32'(r_addr) < 32'(MEM_DEPTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_mode          <= MODE_READ;
         r_addr          <= '0;
         r_data          <= '0;
         r_status        <= ST_OK;
         r_rdata         <= '0;
         r_tx            <= 1'b1;
         r_split_pending <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_cnt           <= w_cnt_next;
         r_status        <= w_status_next;
         r_rdata         <= w_rdata_next;
         r_tx            <= w_tx_next;
         r_split_pending <= w_split_next;
         // Request fields shift in LSB first; they double as the held request in SPLIT_WAIT.
         if (r_state == S_RX_MODE) r_mode <= bus.rx;
         if (r_state == S_RX_ADDR) r_addr <= {bus.rx, r_addr[ADDR_W-1:1]};
         if (r_state == S_RX_DATA) r_data <= {bus.rx, r_data[DATA_W-1:1]};
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_status_next = r_status;
      w_rdata_next  = r_rdata;
      w_split_next  = r_split_pending;
      w_we          = 1'b0;
      w_tx_next     = 1'b1;
      w_stat_bits   = 2'b00;

      case (r_state)
         S_IDLE: begin
            if (!bus.rx) w_state_next = S_RX_MODE;
         end
         S_RX_MODE: begin
            w_cnt_next   = '0;
            w_state_next = S_RX_ADDR;
         end
         S_RX_ADDR: begin
            if (r_cnt == CNT_W'(ADDR_W - 1)) begin
               w_cnt_next   = '0;
               w_state_next = (r_mode == MODE_WRITE) ? S_RX_DATA : S_EXEC;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_RX_DATA: begin
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
               w_cnt_next   = '0;
               w_state_next = S_EXEC;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_EXEC: begin
            w_state_next = S_TX_START;
            if (!w_addr_ok) begin
               w_status_next = ST_ERR;
            end else if (bus.busy) begin
               w_status_next = ST_SPLIT;
               w_split_next  = 1'b1;
            end else begin
               w_status_next = ST_OK;
               w_we          = (r_mode == MODE_WRITE);
               w_rdata_next  = w_mem_rdata;
            end
         end
         S_SPLIT_WAIT: begin
            if (!bus.busy) begin
               w_status_next = ST_RESUME;
               w_we          = (r_mode == MODE_WRITE);
               w_rdata_next  = w_mem_rdata;
               w_state_next  = S_TX_START;
            end
         end
         S_TX_START: begin
            w_cnt_next   = '0;
            w_state_next = S_TX_STAT;
         end
         S_TX_STAT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_cnt_next   = '0;
               w_state_next = frame_has_data(r_mode, r_status) ? S_TX_DATA : S_TX_STOP;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_TX_DATA: begin
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
               w_cnt_next   = '0;
               w_state_next = S_TX_STOP;
            end else begin
               w_cnt_next   = r_cnt + CNT_W'(1);
               w_rdata_next = r_rdata >> 1;
            end
         end
         S_TX_STOP: begin
            w_state_next = (r_status == ST_SPLIT) ? S_SPLIT_WAIT : S_IDLE;
            if (r_status == ST_RESUME) w_split_next = 1'b0;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // tx is registered, so it is driven from the state about to be entered.
      w_stat_bits = w_status_next;
      case (w_state_next)
         S_TX_START: w_tx_next = 1'b0;
         S_TX_STAT:  w_tx_next = w_stat_bits[w_cnt_next[0]];
         S_TX_DATA:  w_tx_next = w_rdata_next[0];
         default:    w_tx_next = 1'b1;
      endcase
   end

   assign bus.tx            = r_tx;
   assign bus.ready         = (r_state == S_IDLE);
   assign bus.split_pending = r_split_pending;

endmodule

// File: tb/tb_serial_slave_port.sv
// Scoreboard bench for serial_slave_port: stimulus pushes expected response
// frames built from a reference memory, a monitor decodes tx and compares.
module tb_serial_slave_port;
   import serial_bus_pkg::*;

   localparam int ADDR_W    = 12;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 2048;

   typedef struct {
      logic [31:0] bits;
      int          len;
      int          start;
      logic        sp;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_busy = 1'b0;
   exp_t exp_q[$];

   logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
   logic [ADDR_W-1:0] pool[$];
   bit                pend_wr;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_data;

   serial_slave_port_if bus ();

   serial_slave_port #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Response frame from the protocol rules: start 0, status LSB first, optional data, stop 1.
   function automatic exp_t mk(input status_e st, input bit with_data, input logic [DATA_W-1:0] d,
                               input int start, input string name);
      exp_t       e;
      logic [1:0] s;
      s       = st;
      e.len   = with_data ? 4 + DATA_W : 4;
      e.bits  = '1;
      e.bits[0] = 1'b0;
      e.bits[1] = s[0];
      e.bits[2] = s[1];
      if (with_data) for (int i = 0; i < DATA_W; i++) e.bits[3+i] = d[i];
      e.start = start;
      e.sp    = (st == ST_SPLIT) || (st == ST_RESUME);
      e.name  = name;
      return e;
   endfunction

   initial begin : monitor
      exp_t        e;
      logic [31:0] got;
      int          t0;
      bit          have;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && bus.tx === 1'b0) begin
            mon_busy = 1'b1;
            t0   = cyc;
            have = (exp_q.size() != 0);
            if (have) e = exp_q.pop_front();
            else      e = mk(ST_OK, 1'b0, '0, -1, "unexpected");
            if (have) begin
               check({e.name, " split_pending@start"}, 32'(bus.split_pending), 32'(e.sp));
               check({e.name, " ready@start"}, 32'(bus.ready), 32'(0));
            end
            got    = '1;
            got[0] = 1'b0;
            for (int i = 1; i < e.len; i++) begin
               @(negedge clk);
               got[i] = bus.tx;
            end
            if (have) begin
               check({e.name, " split_pending@stop"}, 32'(bus.split_pending), 32'(e.sp));
               check({e.name, " frame"}, got, e.bits);
               check({e.name, " start_cycle"}, 32'(t0), 32'(e.start));
               $display("frame %s bits=0x%0h start=%0d", e.name, got, t0);
            end else begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got bits 0x%0h at cycle %0d, required no response", got, t0);
            end
            mon_busy = 1'b0;
         end
      end
   end

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         @(negedge clk);
         ok = (bus.ready === 1'b1) && (exp_q.size() == 0) && !mon_busy;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: ready=%0b pending_frames=%0d, required idle within 400 cycles",
                  bus.ready, exp_q.size());
      end
   endtask

   task automatic wait_frames();
      bit ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         @(negedge clk);
         ok = (exp_q.size() == 0) && !mon_busy;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: pending_frames=%0d, required 0 within 400 cycles", exp_q.size());
      end
   endtask

   task automatic send_bits(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int nbits, output int last);
      logic [31:0] b;
      int          n;
      b    = '1;
      b[0] = 1'b0;
      b[1] = wr;
      for (int i = 0; i < ADDR_W; i++) b[2+i] = a[i];
      for (int i = 0; i < DATA_W; i++) b[2+ADDR_W+i] = d[i];
      n = wr ? 2 + ADDR_W + DATA_W : 2 + ADDR_W;
      if (nbits < n) n = nbits;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.rx = b[i];
      end
      last = cyc;
   endtask

   task automatic do_op(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit busy_req, input bit drop_in_exec);
      int    last;
      string nm;
      wait_idle();
      bus.busy = busy_req;
      send_bits(wr, a, d, 64, last);
      @(negedge clk);
      bus.rx = 1'b1;
      if (drop_in_exec) bus.busy = 1'b0;
      nm = $sformatf("%s@%03h", wr ? "wr" : "rd", a);
      if (int'(a) >= MEM_DEPTH) begin
         exp_q.push_back(mk(ST_ERR, 1'b0, '0, last + 2, nm));
      end else if (busy_req && !drop_in_exec) begin
         exp_q.push_back(mk(ST_SPLIT, 1'b0, '0, last + 2, nm));
         pend_wr   = wr;
         pend_addr = a;
         pend_data = d;
      end else if (wr) begin
         ref_mem[a[10:0]] = d;
         exp_q.push_back(mk(ST_OK, 1'b0, '0, last + 2, nm));
      end else begin
         exp_q.push_back(mk(ST_OK, 1'b1, ref_mem[a[10:0]], last + 2, nm));
      end
      $display("request %s data=0x%02h busy=%0b drop_in_exec=%0b", nm, d, busy_req, drop_in_exec);
   endtask

   task automatic release_busy();
      string nm;
      @(negedge clk);
      bus.busy = 1'b0;
      nm = $sformatf("resume_%s@%03h", pend_wr ? "wr" : "rd", pend_addr);
      if (pend_wr) begin
         ref_mem[pend_addr[10:0]] = pend_data;
         exp_q.push_back(mk(ST_RESUME, 1'b0, '0, cyc + 1, nm));
      end else begin
         exp_q.push_back(mk(ST_RESUME, 1'b1, ref_mem[pend_addr[10:0]], cyc + 1, nm));
      end
   endtask

   task automatic pulse_reset(input string nm);
      #2 rst = 1'b1;
      #1;
      check({nm, " tx"}, 32'(bus.tx), 32'(1));
      check({nm, " ready"}, 32'(bus.ready), 32'(1));
      check({nm, " split_pending"}, 32'(bus.split_pending), 32'(0));
      @(negedge clk);
      bus.rx = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : stim
      int                last;
      bit                wr;
      bit                bz;
      bit                drop;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;

      bus.rx   = 1'b1;
      bus.busy = 1'b0;
      repeat (3) @(negedge clk);
      check("reset tx", 32'(bus.tx), 32'(1));
      check("reset ready", 32'(bus.ready), 32'(1));
      check("reset split_pending", 32'(bus.split_pending), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      check("post_reset ready", 32'(bus.ready), 32'(1));

      do_op(1'b1, 12'h005, 8'hA5, 1'b0, 1'b0);
      do_op(1'b0, 12'h005, 8'h00, 1'b0, 1'b0);
      do_op(1'b1, 12'h000, 8'h5A, 1'b0, 1'b0);
      do_op(1'b1, 12'h010, 8'h3C, 1'b0, 1'b0);

      // Split read; a request sent while waiting must be ignored entirely.
      do_op(1'b0, 12'h010, 8'h00, 1'b1, 1'b0);
      wait_frames();
      @(negedge clk);
      check("split_wait split_pending", 32'(bus.split_pending), 32'(1));
      check("split_wait ready", 32'(bus.ready), 32'(0));
      send_bits(1'b1, 12'h010, 8'hFF, 64, last);
      @(negedge clk);
      bus.rx = 1'b1;
      repeat (200) @(negedge clk);
      release_busy();
      wait_idle();
      check("after_resume split_pending", 32'(bus.split_pending), 32'(0));
      do_op(1'b0, 12'h010, 8'h00, 1'b0, 1'b0);

      do_op(1'b1, 12'h020, 8'h77, 1'b1, 1'b0);
      wait_frames();
      repeat (30) @(negedge clk);
      release_busy();
      do_op(1'b0, 12'h020, 8'h00, 1'b0, 1'b0);

      do_op(1'b0, 12'h800, 8'h00, 1'b0, 1'b0);
      do_op(1'b1, 12'h800, 8'h12, 1'b0, 1'b0);
      do_op(1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
      do_op(1'b1, 12'h7FF, 8'hC3, 1'b0, 1'b0);
      do_op(1'b0, 12'h7FF, 8'h00, 1'b0, 1'b0);
      do_op(1'b0, 12'hFFF, 8'h00, 1'b1, 1'b0);

      do_op(1'b1, 12'h030, 8'h99, 1'b1, 1'b1);
      do_op(1'b0, 12'h030, 8'h00, 1'b1, 1'b1);

      wait_idle();
      send_bits(1'b0, 12'h005, 8'h00, 7, last);
      pulse_reset("rst_mid_addr");
      wait_idle();
      send_bits(1'b1, 12'h005, 8'h11, 18, last);
      pulse_reset("rst_mid_data");
      do_op(1'b0, 12'h005, 8'h00, 1'b0, 1'b0);

      do_op(1'b0, 12'h005, 8'h00, 1'b1, 1'b0);
      wait_frames();
      repeat (5) @(negedge clk);
      check("pre_reset split_pending", 32'(bus.split_pending), 32'(1));
      pulse_reset("rst_split_wait");
      bus.busy = 1'b0;
      repeat (60) @(negedge clk);
      do_op(1'b0, 12'h005, 8'h00, 1'b0, 1'b0);

      pool.push_back(12'h005);
      pool.push_back(12'h000);
      pool.push_back(12'h010);
      pool.push_back(12'h020);
      pool.push_back(12'h030);
      pool.push_back(12'h7FF);
      for (int k = 0; k < 40; k++) begin
         wr   = 1'($urandom_range(0, 1));
         bz   = ($urandom_range(0, 3) == 0);
         drop = bz && ($urandom_range(0, 3) == 0);
         d    = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            a = 12'h800 + 12'($urandom_range(0, 2047));
         end else if (wr && $urandom_range(0, 1) == 1) begin
            a = 12'($urandom_range(0, MEM_DEPTH - 1));
            pool.push_back(a);
         end else begin
            a = pool[$urandom_range(0, pool.size() - 1)];
         end
         do_op(wr, a, d, bz, drop);
         if (bz && !drop && int'(a) < MEM_DEPTH) begin
            wait_frames();
            repeat ($urandom_range(1, 20)) @(negedge clk);
            release_busy();
         end
      end

      wait_idle();
      repeat (20) @(negedge clk);
      check("frames_outstanding", 32'(exp_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
